// File: rtl/uart_rx_ctrl.sv
// UART RX control: staged line-config switch-over gated on line idle, receive FIFO, frame-error count.
// Optional frame-error counter enabled by defining UART_RX_CTRL_ERRCNT_EN.
module uart_rx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [5:0]       cfg_prescale,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  output logic             cfg_busy,
  input  logic             rx_in,
  output logic [5:0]       prescale,
  output logic             par_en,
  output logic             par_typ,
  output logic             rx_rst,
  input  logic             data_valid_rx,
  input  logic [WIDTH-1:0] p_data_rx,
  input  logic             par_err,
  input  logic             stp_err,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic [7:0]       err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, APPLY = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [9:0] idle_cnt, idle_d, thr;
  logic [5:0] pend_pre, cap_pre;
  logic       pend_par_en, pend_par_typ;
  logic       capture, load;

  // Idle window is 12 bit-times of the prescale currently driving the receiver.
  assign thr     = ({4'b0, prescale} << 3) + ({4'b0, prescale} << 2) - 10'd1;
  assign cap_pre = (cfg_prescale < 6'd4) ? 6'd4 : cfg_prescale;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_cnt;
    capture = 1'b0;
    load    = 1'b0;
    case (state_q)
      RUN: if (cfg_wr) begin
        capture = 1'b1;
        idle_d  = '0;
        state_d = PEND;
      end
      PEND: begin
        if (cfg_wr) begin
          capture = 1'b1;
          idle_d  = '0;
        end else if (!rx_in) idle_d = '0;
        else if (idle_cnt == thr) state_d = APPLY;
        else idle_d = idle_cnt + 10'd1;
      end
      APPLY: begin
        load    = 1'b1;
        state_d = RUN;
        if (cfg_wr) begin
          capture = 1'b1;
          idle_d  = '0;
          state_d = PEND;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt     <= '0;
      pend_pre     <= '0;
      pend_par_en  <= 1'b0;
      pend_par_typ <= 1'b0;
      prescale     <= 6'd8;
      par_en       <= 1'b1;
      par_typ      <= 1'b0;
    end else begin
      idle_cnt <= idle_d;
      if (capture) begin
        pend_pre     <= cap_pre;
        pend_par_en  <= cfg_par_en;
        pend_par_typ <= cfg_par_typ;
      end
      // load sees the old pending values even if a new capture lands this cycle
      if (load) begin
        prescale <= pend_pre;
        par_en   <= pend_par_en;
        par_typ  <= pend_par_typ;
      end
    end
  end

  assign cfg_busy = (state_q != RUN);
  assign rx_rst   = rst | (state_q == APPLY);

  // Receive FIFO, first-word fall-through; push strobe is registered off the valid edge.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] push_data;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             dv_q, push_q, pop, wr;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = rd_en & ~empty;
  assign wr      = push_q & (~full | pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      push_data <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dv_q      <= 1'b0;
      push_q    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dv_q      <= data_valid_rx;
      push_q    <= data_valid_rx & ~dv_q;
      push_data <= p_data_rx;
      if (wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_q & full & ~pop) overrun <= 1'b1;
      else if (ovr_clr)         overrun <= 1'b0;
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= par_err | stp_err;
      if ((par_err | stp_err) & ~err_q && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic err_unused;
  assign err_unused = par_err | stp_err;
  assign err_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config switch-over timing, FIFO behaviour, error counter.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst, cfg_wr, cfg_par_en, cfg_par_typ, cfg_busy, rx_in;
  logic [5:0] cfg_prescale, prescale;
  logic       par_en, par_typ, rx_rst, data_valid_rx, par_err, stp_err;
  logic [7:0] p_data_rx, rd_data, err_cnt;
  logic       rd_en, empty, full, overrun, ovr_clr;

  int total = 0;
  int bad   = 0;
  int busy_n, rstp_n, rst_at, wait_n;

  uart_rx_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
    .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .cfg_busy(cfg_busy),
    .rx_in(rx_in), .prescale(prescale), .par_en(par_en), .par_typ(par_typ),
    .rx_rst(rx_rst), .data_valid_rx(data_valid_rx), .p_data_rx(p_data_rx),
    .par_err(par_err), .stp_err(stp_err), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .overrun(overrun), .ovr_clr(ovr_clr),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue cfg_wr for one cycle, then count busy cycles and the rx_rst pulse (bounded).
  task automatic run_cfg(input logic [5:0] p, input logic pe, input logic pt,
                         output int busy, output int rstp, output int at);
    busy = 0; rstp = 0; at = -1;
    cfg_wr = 1'b1; cfg_prescale = p; cfg_par_en = pe; cfg_par_typ = pt;
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!cfg_busy) break;
      busy++;
      if (rx_rst) begin rstp++; at = i; end
      tick();
    end
  endtask

  task automatic pulse_dv(input logic [7:0] d);
    data_valid_rx = 1'b1; p_data_rx = d;
    tick();
    data_valid_rx = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_prescale = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    rx_in = 1'b1; data_valid_rx = 1'b0; p_data_rx = '0; par_err = 1'b0; stp_err = 1'b0;
    rd_en = 1'b0; ovr_clr = 1'b0;
    tick();
    chk("rst_prescale", 32'(prescale), 32'd8);
    chk("rst_par_en",   32'(par_en),   32'd1);
    chk("rst_par_typ",  32'(par_typ),  32'd0);
    chk("rst_rx_rst",   32'(rx_rst),   32'd1);
    chk("rst_busy",     32'(cfg_busy), 32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overrun",  32'(overrun),  32'd0);
    chk("rst_err_cnt",  32'(err_cnt),  32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    rst = 1'b0;
    tick();
    chk("run_rx_rst", 32'(rx_rst), 32'd0);

    // P=8 -> 97 busy cycles, APPLY in the last one
    run_cfg(6'd16, 1'b0, 1'b1, busy_n, rstp_n, rst_at);
    chk("cfg1_busy_cycles", 32'(busy_n), 32'd97);
    chk("cfg1_rst_pulses",  32'(rstp_n), 32'd1);
    chk("cfg1_rst_at",      32'(rst_at), 32'd96);
    chk("cfg1_prescale",    32'(prescale), 32'd16);
    chk("cfg1_par_en",      32'(par_en),   32'd0);
    chk("cfg1_par_typ",     32'(par_typ),  32'd1);

    // P=16 -> threshold 192 -> 193 busy cycles
    run_cfg(6'd10, 1'b1, 1'b0, busy_n, rstp_n, rst_at);
    chk("cfg2_busy_cycles", 32'(busy_n), 32'd193);
    chk("cfg2_rst_pulses",  32'(rstp_n), 32'd1);
    chk("cfg2_prescale",    32'(prescale), 32'd10);

    // reset mid-PEND discards pending config
    cfg_wr = 1'b1; cfg_prescale = 6'd20;
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pend_busy", 32'(cfg_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",     32'(cfg_busy), 32'd0);
    chk("midrst_prescale", 32'(prescale), 32'd8);
    for (int i = 0; i < 150; i++) tick();
    chk("midrst_no_apply", 32'(prescale), 32'd8);

    // line drop at idle_cnt=50 restarts the window; prescale 2 clamps to 4
    cfg_wr = 1'b1; cfg_prescale = 6'd2; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    wait_n = -1;
    for (int i = 0; i < 400; i++) begin
      if (rx_rst) begin wait_n = i; break; end
      tick();
    end
    chk("restart_apply_delay", 32'(wait_n), 32'd96);
    tick();
    chk("clamp_prescale", 32'(prescale), 32'd4);
    chk("clamp_par_typ",  32'(par_typ),  32'd1);
    chk("clamp_busy",     32'(cfg_busy), 32'd0);

    // FIFO latency and overflow
    data_valid_rx = 1'b1; p_data_rx = 8'hA1;
    tick();
    data_valid_rx = 1'b0;
    chk("fifo_lat_n1_empty", 32'(empty), 32'd1);
    tick();
    chk("fifo_lat_n2_empty", 32'(empty),   32'd0);
    chk("fifo_lat_n2_data",  32'(rd_data), 32'hA1);
    for (int k = 2; k <= 5; k++) pulse_dv(8'(8'hA0 + k));
    chk("ovf_full",    32'(full),    32'd1);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_pop_data", 32'(rd_data), 32'(8'hA0 + k));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("ovf_drained_empty", 32'(empty),   32'd1);
    chk("ovf_still_sticky",  32'(overrun), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_on_empty", 32'(empty), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // full FIFO, simultaneous push and pop
    for (int k = 0; k < 4; k++) pulse_dv(8'(8'hB0 + k));
    chk("pp_full_before", 32'(full),    32'd1);
    chk("pp_no_ovr_yet",  32'(overrun), 32'd0);
    data_valid_rx = 1'b1; p_data_rx = 8'hB4;
    tick();
    data_valid_rx = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pp_full_after", 32'(full),    32'd1);
    chk("pp_overrun",    32'(overrun), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("pp_pop_data", 32'(rd_data), 32'(8'hB0 + k));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("pp_empty", 32'(empty), 32'd1);

    // frame-error counter
    for (int k = 0; k < 3; k++) begin
      stp_err = 1'b1; tick();
      stp_err = 1'b0; tick();
    end
`ifdef UART_RX_CTRL_ERRCNT_EN
    chk("err_cnt_3", 32'(err_cnt), 32'd3);
`else
    chk("err_cnt_3", 32'(err_cnt), 32'd0);
`endif
    for (int k = 0; k < 300; k++) begin
      par_err = 1'b1; tick();
      par_err = 1'b0; tick();
    end
`ifdef UART_RX_CTRL_ERRCNT_EN
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
`else
    chk("err_cnt_sat", 32'(err_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
